// File: rtl/actor_motion_pkg.sv
// meikyuu_pkg: shared constants and encodings for the maze actor.
// VGA timing constants, direction encoding, actor FSM state encoding and
// the direction-priority helpers used by actor_motion.
package meikyuu_pkg;

    // 640x480 VGA horizontal timing: sync, back porch, active, front porch
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_ACT    = 640;
    localparam int H_FRONT  = 16;
    // 640x480 VGA vertical timing
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_ACT    = 480;
    localparam int V_FRONT  = 10;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MOVE    = 2'd1,
        ST_BLOCKED = 2'd2,
        ST_SETTLE  = 2'd3
    } actor_state_t;

    // Single-axis priority: left > down > up > right (inputs active-high)
    function automatic dir_t pick_dir(input logic up, input logic down,
                                      input logic left, input logic right);
        dir_t d;
        if (left)       d = DIR_LEFT;
        else if (down)  d = DIR_DOWN;
        else if (up)    d = DIR_UP;
        else if (right) d = DIR_RIGHT;
        else            d = DIR_UP;
        return d;
    endfunction

    // Diagonal mode: report the horizontal component first
    function automatic dir_t pick_dir_diag(input logic up, input logic down,
                                           input logic left, input logic right);
        dir_t d;
        if (left)       d = DIR_LEFT;
        else if (right) d = DIR_RIGHT;
        else if (down)  d = DIR_DOWN;
        else if (up)    d = DIR_UP;
        else            d = DIR_UP;
        return d;
    endfunction

endpackage

// File: rtl/actor_motion_if.sv
// actor_motion_if: buttons/collision in, position/room/status out.
// master = button synchroniser / collision side, slave = actor_motion.
interface actor_motion_if #(
    parameter int MAP_BITS = 3
);
    logic                btn_up;
    logic                btn_down;
    logic                btn_left;
    logic                btn_right;
    logic                collision;
    logic [9:0]          x_pos;
    logic [9:0]          y_pos;
    logic [MAP_BITS-1:0] mapa_x;
    logic [MAP_BITS-1:0] mapa_y;
    logic [1:0]          dir;
    logic                moving;
    logic                room_change;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, collision,
        input  x_pos, y_pos, mapa_x, mapa_y, dir, moving, room_change
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, collision,
        output x_pos, y_pos, mapa_x, mapa_y, dir, moving, room_change
    );
endinterface

// File: rtl/actor_motion_step_timer.sv
// actor_step_timer: free-running step counter for held buttons.
// Counts while enabled, wraps at STEP_PERIOD-1 and flags that cycle on o_tick.
module actor_step_timer #(
    parameter int STEP_PERIOD = 150000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam int CW = $clog2(STEP_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(STEP_PERIOD - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    // Step counter: clear has priority, wrap on tick, else count when enabled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        r_cnt <= {CW{1'b0}};
        else if (i_clr)   r_cnt <= {CW{1'b0}};
        else if (o_tick)  r_cnt <= {CW{1'b0}};
        else if (i_en)    r_cnt <= r_cnt + CW'(1);
        else              r_cnt <= r_cnt;
    end
endmodule

// File: rtl/actor_motion.sv
// actor_motion: maze actor movement controller.
// Optional feature macro: ACTOR_DIAGONAL_EN (two orthogonal buttons step
// both axes on the same tick). Undefined: single axis, left>down>up>right.
module actor_motion
    import meikyuu_pkg::*;
#(
    parameter int H_START     = H_SYNC + H_BACK - H_FRONT,
    parameter int V_START     = V_SYNC + V_BACK,
    parameter int H_ACTIVE    = H_ACT,
    parameter int V_ACTIVE    = V_ACT,
    parameter int SPRITE      = 16,
    parameter int STEP_PERIOD = 150000,
    parameter int STEP_PX     = 1,
    parameter int MAP_BITS    = 3,
    parameter int START_X     = 455,
    parameter int START_Y     = 266,
    parameter int START_MX    = 0,
    parameter int START_MY    = 7,
    parameter int SETTLE      = 2
) (
    input  logic           CLOCK_25,
    input  logic           reset,
    actor_motion_if.slave  bus
);
    localparam logic [10:0] X_MIN = 11'(H_START);
    localparam logic [10:0] X_MAX = 11'(H_START + H_ACTIVE - SPRITE);
    localparam logic [10:0] Y_MIN = 11'(V_START);
    localparam logic [10:0] Y_MAX = 11'(V_START + V_ACTIVE - SPRITE);
    localparam logic [10:0] STEP  = 11'(STEP_PX);
    localparam int          SW    = $clog2(SETTLE + 1);

    actor_state_t        r_state, w_state_nxt;
    logic [9:0]          r_x, r_y, r_px, r_py, w_x_nxt, w_y_nxt, w_px_nxt, w_py_nxt;
    logic [MAP_BITS-1:0] r_mx, r_my, w_mx_nxt, w_my_nxt;
    dir_t                r_dir, w_dir_nxt, w_dir_req;
    logic                r_moving, r_room_change, w_rc_nxt;
    logic [SW-1:0]       r_settle, w_settle_nxt;
    logic                w_tick, w_tmr_clr, w_any;
    logic                w_go_l, w_go_r, w_go_u, w_go_d;
    logic [10:0]         w_x_dec, w_x_inc, w_y_dec, w_y_inc;
    logic                w_wrap_l, w_wrap_r, w_wrap_u, w_wrap_d;
    logic [9:0]          w_x_step, w_y_step;

    actor_step_timer #(.STEP_PERIOD(STEP_PERIOD)) u_timer (
        .i_clk  (CLOCK_25),
        .i_rst  (reset),
        .i_clr  (w_tmr_clr),
        .i_en   (r_state == ST_MOVE),
        .o_tick (w_tick)
    );

    assign w_any = ~bus.btn_up | ~bus.btn_down | ~bus.btn_left | ~bus.btn_right;

    // Requested direction and which axes the next step drives
    always_comb begin
`ifdef ACTOR_DIAGONAL_EN
        w_dir_req = pick_dir_diag(~bus.btn_up, ~bus.btn_down, ~bus.btn_left, ~bus.btn_right);
        w_go_l    = ~bus.btn_left;
        w_go_r    = ~bus.btn_right & bus.btn_left;
        w_go_d    = ~bus.btn_down;
        w_go_u    = ~bus.btn_up & bus.btn_down;
`else
        w_dir_req = pick_dir(~bus.btn_up, ~bus.btn_down, ~bus.btn_left, ~bus.btn_right);
        w_go_l    = (r_dir == DIR_LEFT);
        w_go_r    = (r_dir == DIR_RIGHT);
        w_go_d    = (r_dir == DIR_DOWN);
        w_go_u    = (r_dir == DIR_UP);
`endif
    end

    // 11-bit step arithmetic so an underflow past the left/top edge is visible
    always_comb begin
        w_x_dec  = {1'b0, r_x} - STEP;
        w_x_inc  = {1'b0, r_x} + STEP;
        w_y_dec  = {1'b0, r_y} - STEP;
        w_y_inc  = {1'b0, r_y} + STEP;
        w_wrap_l = w_go_l && (w_x_dec[10] || (w_x_dec < X_MIN));
        w_wrap_r = w_go_r && (w_x_inc > X_MAX);
        w_wrap_u = w_go_u && (w_y_dec[10] || (w_y_dec < Y_MIN));
        w_wrap_d = w_go_d && (w_y_inc > Y_MAX);
        if (w_go_l)      w_x_step = w_wrap_l ? X_MAX[9:0] : w_x_dec[9:0];
        else if (w_go_r) w_x_step = w_wrap_r ? X_MIN[9:0] : w_x_inc[9:0];
        else             w_x_step = r_x;
        if (w_go_u)      w_y_step = w_wrap_u ? Y_MAX[9:0] : w_y_dec[9:0];
        else if (w_go_d) w_y_step = w_wrap_d ? Y_MIN[9:0] : w_y_inc[9:0];
        else             w_y_step = r_y;
    end

    // Next-state and next-datapath logic for the actor FSM
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_px_nxt     = r_px;
        w_py_nxt     = r_py;
        w_mx_nxt     = r_mx;
        w_my_nxt     = r_my;
        w_dir_nxt    = r_dir;
        w_rc_nxt     = 1'b0;
        w_settle_nxt = r_settle;
        w_tmr_clr    = (r_state != ST_MOVE);
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_MOVE;
                    w_dir_nxt   = w_dir_req;
                    w_px_nxt    = r_x;
                    w_py_nxt    = r_y;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (bus.collision) begin
                    // rollback beats any step due on this edge
                    w_x_nxt     = r_px;
                    w_y_nxt     = r_py;
                    w_state_nxt = ST_BLOCKED;
                end else if (!w_any) begin
                    w_state_nxt = ST_IDLE;
                    w_tmr_clr   = 1'b1;
                end else if (w_dir_req != r_dir) begin
                    w_dir_nxt   = w_dir_req;
                    w_tmr_clr   = 1'b1;
                end else if (w_tick) begin
                    w_px_nxt = r_x;
                    w_py_nxt = r_y;
                    w_x_nxt  = w_x_step;
                    w_y_nxt  = w_y_step;
                    if (w_wrap_l || w_wrap_r || w_wrap_u || w_wrap_d) begin
                        if (w_wrap_l)      w_mx_nxt = r_mx - MAP_BITS'(1);
                        else if (w_wrap_r) w_mx_nxt = r_mx + MAP_BITS'(1);
                        else               w_mx_nxt = r_mx;
                        if (w_wrap_u)      w_my_nxt = r_my - MAP_BITS'(1);
                        else if (w_wrap_d) w_my_nxt = r_my + MAP_BITS'(1);
                        else               w_my_nxt = r_my;
                        w_rc_nxt     = 1'b1;
                        w_settle_nxt = {SW{1'b0}};
                        w_state_nxt  = ST_SETTLE;
                    end else begin
                        w_state_nxt = ST_MOVE;
                    end
                end else begin
                    w_state_nxt = ST_MOVE;
                end
            end
            ST_BLOCKED: begin
                if (!w_any) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_dir_req != r_dir) begin
                    w_state_nxt = ST_MOVE;
                    w_dir_nxt   = w_dir_req;
                    w_px_nxt    = r_x;
                    w_py_nxt    = r_y;
                end else begin
                    w_state_nxt = ST_BLOCKED;
                end
            end
            ST_SETTLE: begin
                // collision deliberately ignored while the new room settles
                if (r_settle == SW'(SETTLE - 1)) begin
                    if (w_any) begin
                        w_state_nxt = ST_MOVE;
                        w_dir_nxt   = w_dir_req;
                        w_px_nxt    = r_x;
                        w_py_nxt    = r_y;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_settle_nxt = r_settle + SW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_x           <= 10'(START_X);
            r_y           <= 10'(START_Y);
            r_px          <= 10'(START_X);
            r_py          <= 10'(START_Y);
            r_mx          <= MAP_BITS'(START_MX);
            r_my          <= MAP_BITS'(START_MY);
            r_dir         <= DIR_UP;
            r_moving      <= 1'b0;
            r_room_change <= 1'b0;
            r_settle      <= {SW{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_px          <= w_px_nxt;
            r_py          <= w_py_nxt;
            r_mx          <= w_mx_nxt;
            r_my          <= w_my_nxt;
            r_dir         <= w_dir_nxt;
            r_moving      <= (w_state_nxt == ST_MOVE);
            r_room_change <= w_rc_nxt;
            r_settle      <= w_settle_nxt;
        end
    end

    assign bus.x_pos       = r_x;
    assign bus.y_pos       = r_y;
    assign bus.mapa_x      = r_mx;
    assign bus.mapa_y      = r_my;
    assign bus.dir         = r_dir;
    assign bus.moving      = r_moving;
    assign bus.room_change = r_room_change;
endmodule

// File: tb/tb_actor_motion.sv
// Directed bench for actor_motion with STEP_PERIOD=4 and default geometry.
// Honours ACTOR_DIAGONAL_EN in the left+up step.
module tb_actor_motion;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic found;

    actor_motion_if #(.MAP_BITS(3)) bus ();

    actor_motion #(.STEP_PERIOD(4)) dut (
        .CLOCK_25 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x"},  32'(bus.x_pos), 32'd455);
        check({tag, "_y"},  32'(bus.y_pos), 32'd266);
        check({tag, "_mx"}, 32'(bus.mapa_x), 32'd0);
        check({tag, "_my"}, 32'(bus.mapa_y), 32'd7);
        check({tag, "_dir"}, 32'(bus.dir), 32'd0);
        check({tag, "_mov"}, 32'(bus.moving), 32'd0);
        check({tag, "_rc"}, 32'(bus.room_change), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.btn_up = 1'b1; bus.btn_down = 1'b1; bus.btn_left = 1'b1; bus.btn_right = 1'b1;
        bus.collision = 1'b0;
        tick(3);
        rst = 1'b0;
        check_reset_vals("rst");
        tick(1000);
        check_reset_vals("idle1000");

        // right held: step lands STEP_PERIOD+1 edges after press
        bus.btn_right = 1'b0;
        tick(1);
        check("r_mov", 32'(bus.moving), 32'd1);
        check("r_dir", 32'(bus.dir), 32'd3);
        tick(3);
        check("r_x_e4", 32'(bus.x_pos), 32'd455);
        tick(1);
        check("r_x_e5", 32'(bus.x_pos), 32'd456);
        tick(4);
        check("r_x_e9", 32'(bus.x_pos), 32'd457);
        bus.btn_right = 1'b1;
        tick(1);
        check("r_rel_mov", 32'(bus.moving), 32'd0);
        check("r_rel_x", 32'(bus.x_pos), 32'd457);

        // left held down to H_START, then wrap to the right edge of room 7
        bus.btn_left = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick(1);
            if (bus.x_pos == 10'd128) found = 1'b1;
        end
        check("reach_hstart", 32'(found), 32'd1);
        tick(3);
        check("w_x_pre", 32'(bus.x_pos), 32'd128);
        check("w_rc_pre", 32'(bus.room_change), 32'd0);
        tick(1);
        check("w_x", 32'(bus.x_pos), 32'd752);
        check("w_mx", 32'(bus.mapa_x), 32'd7);
        check("w_my", 32'(bus.mapa_y), 32'd7);
        check("w_rc", 32'(bus.room_change), 32'd1);
        check("w_mov", 32'(bus.moving), 32'd0);
        bus.collision = 1'b1;
        tick(1);
        bus.collision = 1'b0;
        check("s_x", 32'(bus.x_pos), 32'd752);
        check("s_rc", 32'(bus.room_change), 32'd0);
        tick(1);
        check("s_exit_mov", 32'(bus.moving), 32'd1);
        tick(4);
        check("s_step_x", 32'(bus.x_pos), 32'd751);
        bus.btn_left = 1'b1;
        tick(1);
        check("l_rel_mov", 32'(bus.moving), 32'd0);

        // down step, then collision rolls back and blocks
        bus.btn_down = 1'b0;
        tick(5);
        check("d_y", 32'(bus.y_pos), 32'd267);
        check("d_dir", 32'(bus.dir), 32'd1);
        bus.collision = 1'b1;
        tick(1);
        bus.collision = 1'b0;
        check("c_y", 32'(bus.y_pos), 32'd266);
        check("c_mov", 32'(bus.moving), 32'd0);
        tick(12);
        check("b_y", 32'(bus.y_pos), 32'd266);
        check("b_mov", 32'(bus.moving), 32'd0);
        bus.btn_down = 1'b1;
        tick(1);
        bus.btn_up = 1'b0;
        tick(1);
        check("u_mov", 32'(bus.moving), 32'd1);
        check("u_dir", 32'(bus.dir), 32'd0);
        tick(4);
        check("u_y", 32'(bus.y_pos), 32'd265);
        // collision on the same edge as a due step: rollback, no step
        tick(3);
        bus.collision = 1'b1;
        tick(1);
        bus.collision = 1'b0;
        check("cs_y", 32'(bus.y_pos), 32'd266);
        check("cs_mov", 32'(bus.moving), 32'd0);
        bus.btn_up = 1'b1;
        tick(1);

        // left+up together
        bus.btn_left = 1'b0;
        bus.btn_up   = 1'b0;
        tick(4);
        check("lu_x_e4", 32'(bus.x_pos), 32'd751);
        tick(1);
        check("lu_x", 32'(bus.x_pos), 32'd750);
        check("lu_dir", 32'(bus.dir), 32'd2);
`ifdef ACTOR_DIAGONAL_EN
        check("lu_y", 32'(bus.y_pos), 32'd265);
`else
        check("lu_y", 32'(bus.y_pos), 32'd266);
`endif
        bus.btn_left = 1'b1;
        bus.btn_up   = 1'b1;
        tick(1);

        // asynchronous reset in the middle of MOVE
        bus.btn_right = 1'b0;
        tick(3);
        check("ar_pre_mov", 32'(bus.moving), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async");
        bus.btn_right = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check_reset_vals("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/actor_motion.md
# actor_motion

Parametrised movement controller for a maze actor: owns the sprite's screen position and map-room coordinates, turns active-low direction buttons into fixed-rate pixel steps, and undoes any step that produces a collision. Sits between the button synchroniser and the VGA renderer/collision checker. It replaces the single-player mover with configurable screen geometry, step rate, step size and map size, explicit collision rollback, and a room-change strobe.

## Interface
Parameters:
- H_START, 128: first visible column of the sprite origin (96+48−16).
- V_START, 35: first visible row (2+33).
- H_ACTIVE, 640: visible width in pixels.
- V_ACTIVE, 480: visible height in pixels.
- SPRITE, 16: sprite edge in pixels.
- STEP_PERIOD, 150000: clock cycles per step while held, ≥2.
- STEP_PX, 1: pixels per step, 1..SPRITE.
- MAP_BITS, 3: width of each room coordinate.
- START_X, 455: reset x. START_Y, 266: reset y.
- START_MX, 0: reset room x. START_MY, 7: reset room y.
- SETTLE, 2: cycles after a room change during which collision is ignored.

Ports:
- CLOCK_25  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-high.
- btn_up, btn_down, btn_left, btn_right  in  1 each  active-low, already synchronised.
- collision  in  1  high when the current position overlaps a wall.
- x_pos  out  10  sprite x.
- y_pos  out  10  sprite y.
- mapa_x, mapa_y  out  MAP_BITS each  current room.
- dir  out  2  last direction: 0 up, 1 down, 2 left, 3 right.
- moving  out  1  high in MOVE.
- room_change  out  1  one-cycle strobe on a room transition.

## Operation
- States: IDLE, MOVE, BLOCKED, SETTLE.
- IDLE:
  - Any button pressed → MOVE; dir latched; step timer cleared.
  - Without the diagonal option, priority is left > down > up > right.
- MOVE:
  - Timer counts every cycle.
  - At STEP_PERIOD−1: save (x,y) into prev_x/prev_y, apply ±STEP_PX on the axis, clear the timer.
  - All buttons released → IDLE, timer cleared, position kept.
  - A different button wins priority → stay in MOVE, update dir, clear the timer.
- Collision:
  - collision high in MOVE restores prev_x/prev_y on the next edge → BLOCKED.
  - If no step has happened since entry, prev equals the current position, so the restore is a no-op.
- BLOCKED:
  - No steps.
  - Exits to IDLE when all buttons are released, or to MOVE when a direction different from the blocked dir wins priority.
- Wrap:
  - Applied when a step would move x below H_START, x above H_START+H_ACTIVE−SPRITE, or the same on y with V_START/V_ACTIVE.
  - Position jumps to the opposite edge: left → H_START+H_ACTIVE−SPRITE; right → H_START; up → V_START+V_ACTIVE−SPRITE; down → V_START.
  - The room coordinate changes by ±1 modulo 2^MAP_BITS, e.g. room 0 going left → 7.
  - room_change pulses, then SETTLE.
- SETTLE:
  - Counts SETTLE cycles, ignores collision, then → MOVE if a button is held, else IDLE.
- Arithmetic:
  - The step is computed 11 bits wide, so underflow below H_START is detected before truncation to 10 bits.

## Timing
- Reset values: x_pos=START_X, y_pos=START_Y, mapa_x=START_MX, mapa_y=START_MY, dir=0, moving=0, room_change=0; state IDLE, timer 0.
- All outputs are registered.
- A step appears on x_pos/y_pos at the edge after the timer reaches STEP_PERIOD−1.
- First step lands STEP_PERIOD+1 cycles after the button goes low (1 cycle IDLE→MOVE, then STEP_PERIOD counting).
- Collision → rollback visible 1 cycle later. Collision and a step due on the same edge: the rollback wins and no step is applied.
- Reset mid-operation forces all reset values immediately; a pending step is lost.

## Configuration
- ACTOR_DIAGONAL_EN:
  - Defined: two orthogonal buttons held together step both axes on the same tick. dir reports the horizontal component. Rollback restores both axes. A wrap on either axis counts as one room_change.
  - Undefined: single-axis movement with the fixed priority above.

## Structure
- meikyuu_pkg:
  - VGA timing constants (96/48/640/16, 2/33/480/10).
  - Direction encoding (DIR_UP..DIR_RIGHT).
  - actor state encoding.
- One sub-module, actor_step_timer: holds the STEP_PERIOD counter with clear/enable inputs and a tick output.

## Test plan
- Reset, no buttons for 1000 cycles → outputs hold 455/266/0/7; moving=0.
- STEP_PERIOD=4; btn_right low for 9 cycles → x 455→456 at cycle 5, →457 at cycle 9; dir=3.
- x=H_START, btn_left held, step → x=752, mapa_x 0→7, one-cycle room_change; collision pulsed during SETTLE is ignored.
- btn_down step, then collision high 1 cycle → y returns to its pre-step value; holding down gives no further steps; releasing and pressing up resumes movement.
- Left and up held, macro undefined → only x changes; macro defined → x and y both change on the same tick.
- Reset asserted asynchronously mid-MOVE → all outputs return to reset values before the next clock edge.
